// File: rtl/dot_product_sequencer_if.sv
// -----------------------------------------------------------------------------
// dot_product_sequencer_if
//   Stream bundle for the dot-product sequencer.
//     - Input chunk stream (source -> sequencer):
//         in_valid, in_ready, in_data[63:0], in_weights[63:0]
//         lane i of in_data/in_weights is bits [16i+15:16i]
//     - Result stream (sequencer -> consumer):
//         out_valid, out_ready, out_result[ACC_W-1:0]
//   Modports:
//     master : the environment side (drives chunks, accepts results)
//     slave  : the sequencer side
// -----------------------------------------------------------------------------
interface dot_product_sequencer_if #(
    parameter int unsigned ACC_W = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic [63:0]      in_weights;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_result;

    modport master (
        output in_valid, in_data, in_weights, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_data, in_weights, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/dot_product_sequencer.sv
// -----------------------------------------------------------------------------
// dot_product_sequencer
//   Job-level controller for an external 4-lane pipelined multiply-sum
//   datapath. A job of num_chunks 4-element chunks is accepted over the input
//   stream, each accepted chunk is passed to the datapath, the per-chunk
//   datapath results are accumulated LATENCY cycles later, and the final sum
//   is offered on the result stream.
//
//   Parameters:
//     LATENCY : cycles from issue to the cycle dp_result is valid (>=1)
//     CNT_W   : width of num_chunks
//     ACC_W   : accumulator/result width (>=16)
//
//   Ports:
//     clk        : clock, rising edge
//     rst        : synchronous active-high reset
//     start      : begin a job (sampled only in IDLE)
//     num_chunks : chunk count, sampled with start
//     busy       : high whenever not IDLE
//     bus        : chunk input stream and result output stream (slave side)
//     dp_data    : datapath data, pass-through of bus.in_data
//     dp_weights : datapath weights, pass-through of bus.in_weights
//     dp_result  : per-chunk datapath result
//
//   Build option:
//     ACC_SATURATE_EN : when defined, accumulation saturates at all-ones
//                       instead of wrapping modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module dot_product_sequencer #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ACC_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_chunks,
    output logic                 busy,
    dot_product_sequencer_if.slave bus,
    output logic [63:0]          dp_data,
    output logic [63:0]          dp_weights,
    input  logic [15:0]          dp_result
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LATENCY-1:0] pipe_v_q, pipe_v_d;
    logic [ACC_W-1:0]   acc_sum;
    logic               issue;
    logic               acc_en;
    logic               job_start;

    // ------------------------------------------------------------------
    // Datapath pass-through
    // ------------------------------------------------------------------
    assign dp_data    = bus.in_data;
    assign dp_weights = bus.in_weights;

    assign issue     = bus.in_valid && bus.in_ready;
    assign acc_en    = pipe_v_q[LATENCY-1];
    assign job_start = (state_q == IDLE) && start;

    // In-flight tracker: bit k set means a chunk issued k+1 cycles ago.
    generate
        if (LATENCY > 1) begin : g_shift
            assign pipe_v_d = {pipe_v_q[LATENCY-2:0], issue};
        end else begin : g_single
            assign pipe_v_d = issue;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Accumulator adder
    // ------------------------------------------------------------------
`ifdef ACC_SATURATE_EN
    logic [ACC_W:0] sum_full;

    always_comb begin
        sum_full = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, dp_result};
        // A carry out means the true sum left the range: clamp. Once at
        // all-ones any further nonzero add carries again, so it stays put.
        acc_sum  = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];
    end
`else
    always_comb begin
        acc_sum = acc_q + {{(ACC_W - 16){1'b0}}, dp_result};
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_chunks == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (issue && (remaining_q == CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the tracker empties at this edge, i.e. the
                // edge that performs the final accumulation.
                if (pipe_v_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy           = (state_q != IDLE);
        bus.in_ready   = (state_q == FEED);
        bus.out_valid  = (state_q == DONE);
        bus.out_result = (state_q == DONE) ? acc_q : '0;
    end

    // ------------------------------------------------------------------
    // Job counters and accumulator
    // ------------------------------------------------------------------
    always_comb begin
        acc_d       = acc_q;
        remaining_d = remaining_q;
        if (job_start) begin
            acc_d       = '0;
            remaining_d = num_chunks;
        end else begin
            if (issue) begin
                remaining_d = remaining_q - CNT_W'(1);
            end
            if (acc_en) begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            remaining_q <= '0;
            pipe_v_q    <= '0;
        end else begin
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            pipe_v_q    <= pipe_v_d;
        end
    end

endmodule
